vic_bus_arbiter: RTL and testbench

Bus-cycle scheduler for the VIC-II system bus. Divides `clkSys` into the two-phase system cycle, gives the VIC the phi-low half of every cycle and the CPU the phi-high half, and steals whole cycles for VIC DMA (badline and sprite fetches) using the BA/AEC protocol. Sits beside `VIC6569`; CPU RDY is driven from `o_ba`, and the bus multiplexer is driven from `o_aec`.

---
 rtl/vic_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_vic_bus_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vic_bus_arbiter.sv
// vic_bus_arbiter: bus-cycle scheduler for the VIC-II system bus.
//
// Divides clkSys into a two-phase system cycle. The VIC owns the phi-low half
// (cnt 1..HALF_CYCLE) and the CPU owns the phi-high half
// (cnt HALF_CYCLE+1..2*HALF_CYCLE). DMA requests steal whole cycles through
// the BA/AEC handshake. BA drops three cycles before the first stolen cycle so
// the CPU can finish its pending writes.
//
// Optional feature macro: VIC_ARB_STEAL_COUNT_EN adds o_steal_count, a
// saturating per-line count of stolen cycles.
//
// Ports:
//   clkSys         in   system clock (only clock)
//   reset          in   asynchronous active-high reset
//   i_dma_req      in   VIC DMA request level, sampled at VIC-half start only
//   o_phi0         out  CPU clock: 0 in the VIC half, 1 in the CPU half
//   o_phase_start  out  one-tick pulse on the first tick of each half
//   o_line_start   out  one-tick pulse on the first tick of cycle 0
//   o_cycle        out  cycle index within the raster line
//   o_ba           out  bus available (drives CPU RDY)
//   o_aec          out  address enable: 1 while the CPU drives the bus
//   o_stolen       out  1 for the whole of a stolen cycle
//   o_steal_count  out  stolen cycles this line (VIC_ARB_STEAL_COUNT_EN only)

module vic_bus_arbiter #(
  parameter int HALF_CYCLE      = 25,
  parameter int CYCLES_PER_LINE = 63
) (
  input  logic       clkSys,
  input  logic       reset,
  input  logic       i_dma_req,
  output logic       o_phi0,
  output logic       o_phase_start,
  output logic       o_line_start,
  output logic [5:0] o_cycle,
  output logic       o_ba,
  output logic       o_aec,
  output logic       o_stolen
`ifdef VIC_ARB_STEAL_COUNT_EN
  ,
  output logic [15:0] o_steal_count
`endif
);

  localparam logic [5:0] HALF       = 6'(HALF_CYCLE);
  localparam logic [5:0] FULL       = 6'(2 * HALF_CYCLE);
  localparam logic [5:0] LAST_CYCLE = 6'(CYCLES_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WARN1 = 3'd1,
    WARN2 = 3'd2,
    WARN3 = 3'd3,
    STEAL = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic [5:0] cycle_next;
  logic       vic_start_next;
  logic       phi0_next, phase_start_next, line_start_next;
  logic       ba_next, aec_next, stolen_next;

  // State register: every output is registered from its next-state value so
  // all of them change on the same edge as cnt.
  always_ff @(posedge clkSys or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 6'd0;
      o_cycle       <= LAST_CYCLE;  // first edge after reset lands on cycle 0
      o_phi0        <= 1'b0;
      o_phase_start <= 1'b0;
      o_line_start  <= 1'b0;
      o_ba          <= 1'b1;
      o_aec         <= 1'b0;
      o_stolen      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      o_cycle       <= cycle_next;
      o_phi0        <= phi0_next;
      o_phase_start <= phase_start_next;
      o_line_start  <= line_start_next;
      o_ba          <= ba_next;
      o_aec         <= aec_next;
      o_stolen      <= stolen_next;
    end
  end

  // Next-state: tick counter, cycle counter and the steal FSM. The FSM only
  // moves at VIC-half start, which makes req glitches in between invisible.
  always_comb begin
    cnt_next       = (cnt_reg == FULL) ? 6'd1 : cnt_reg + 6'd1;
    vic_start_next = (cnt_next == 6'd1);
    cycle_next     = o_cycle;
    state_next     = state_reg;
    if (vic_start_next) begin
      cycle_next = (o_cycle == LAST_CYCLE) ? 6'd0 : o_cycle + 6'd1;
      case (state_reg)
        IDLE:    state_next = i_dma_req ? WARN1 : IDLE;
        WARN1:   state_next = i_dma_req ? WARN2 : IDLE;
        WARN2:   state_next = i_dma_req ? WARN3 : IDLE;
        WARN3:   state_next = i_dma_req ? STEAL : IDLE;
        STEAL:   state_next = i_dma_req ? STEAL : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode from next-state values.
  always_comb begin
    phi0_next        = (cnt_next > HALF);
    phase_start_next = (cnt_next == 6'd1) || (cnt_next == HALF + 6'd1);
    line_start_next  = vic_start_next && (cycle_next == 6'd0);
    ba_next          = (state_next == IDLE);
    aec_next         = phi0_next && (state_next != STEAL);
    stolen_next      = (state_next == STEAL);
  end

`ifdef VIC_ARB_STEAL_COUNT_EN
  logic [15:0] count_next;
  logic [15:0] count_base;

  // The line-start clear happens first so a steal in cycle 0 counts as 1.
  always_comb begin
    count_next = o_steal_count;
    count_base = line_start_next ? 16'd0 : o_steal_count;
    if (vic_start_next) begin
      count_next = count_base;
      if (stolen_next && (count_base != 16'hFFFF))
        count_next = count_base + 16'd1;
    end
  end

  always_ff @(posedge clkSys or posedge reset) begin
    if (reset) o_steal_count <= 16'd0;
    else       o_steal_count <= count_next;
  end
`endif

endmodule

// File: tb/tb_vic_bus_arbiter.sv
// Directed testbench for vic_bus_arbiter (default parameters: 25 ticks per
// half, 63 cycles per line). Inputs are driven and outputs sampled 1 time
// unit after each rising clkSys edge. "Tick t" means the t-th rising edge
// after reset release; after tick t the cycle index is ((t-1)/50) mod 63.

module tb_vic_bus_arbiter;

  logic       clkSys = 1'b0;
  logic       reset  = 1'b1;
  logic       i_dma_req = 1'b0;
  logic       o_phi0, o_phase_start, o_line_start;
  logic [5:0] o_cycle;
  logic       o_ba, o_aec, o_stolen;
`ifdef VIC_ARB_STEAL_COUNT_EN
  logic [15:0] o_steal_count;
`endif

  int passed   = 0;
  int total    = 0;
  int now_tick = 0;

  vic_bus_arbiter dut (
    .clkSys        (clkSys),
    .reset         (reset),
    .i_dma_req     (i_dma_req),
    .o_phi0        (o_phi0),
    .o_phase_start (o_phase_start),
    .o_line_start  (o_line_start),
    .o_cycle       (o_cycle),
    .o_ba          (o_ba),
    .o_aec         (o_aec),
    .o_stolen      (o_stolen)
`ifdef VIC_ARB_STEAL_COUNT_EN
    ,
    .o_steal_count (o_steal_count)
`endif
  );

  always #5 clkSys = ~clkSys;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at tick %0d: observed %0h expected %0h", tag, now_tick, obs, exp);
  endtask

  task automatic tick_to(input int t);
    while (now_tick < t) begin
      @(posedge clkSys);
      #1;
      now_tick++;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".phi0"},  16'(o_phi0),        16'd0);
    chk({tag, ".ps"},    16'(o_phase_start), 16'd0);
    chk({tag, ".ls"},    16'(o_line_start),  16'd0);
    chk({tag, ".cycle"}, 16'(o_cycle),       16'd62);
    chk({tag, ".ba"},    16'(o_ba),          16'd1);
    chk({tag, ".aec"},   16'(o_aec),         16'd0);
    chk({tag, ".stol"},  16'(o_stolen),      16'd0);
`ifdef VIC_ARB_STEAL_COUNT_EN
    chk({tag, ".scnt"},  o_steal_count,      16'd0);
`endif
  endtask

  initial begin
    int ls_pulses;
    int cycle_errs;
    int line1;
    int line2;
    logic exp_ba, exp_stol;

    // ---------------- reset sequencing ----------------
    repeat (3) @(posedge clkSys);
    #1;
    chk_reset_values("rst_hold");
    reset = 1'b0;
    now_tick = 0;

    tick_to(1);
    chk("t1.cycle", 16'(o_cycle), 16'd0);
    chk("t1.ls",    16'(o_line_start), 16'd1);
    chk("t1.ps",    16'(o_phase_start), 16'd1);
    chk("t1.phi0",  16'(o_phi0), 16'd0);
    chk("t1.ba",    16'(o_ba), 16'd1);
    chk("t1.aec",   16'(o_aec), 16'd0);
    tick_to(2);
    chk("t2.ps",    16'(o_phase_start), 16'd0);
    chk("t2.ls",    16'(o_line_start), 16'd0);
    tick_to(25);
    chk("t25.phi0", 16'(o_phi0), 16'd0);
    tick_to(26);
    chk("t26.phi0", 16'(o_phi0), 16'd1);
    chk("t26.ps",   16'(o_phase_start), 16'd1);
    chk("t26.aec",  16'(o_aec), 16'd1);
    tick_to(50);
    chk("t50.phi0", 16'(o_phi0), 16'd1);
    tick_to(51);
    chk("t51.phi0", 16'(o_phi0), 16'd0);
    chk("t51.ps",   16'(o_phase_start), 16'd1);
    chk("t51.cycle",16'(o_cycle), 16'd1);
    chk("t51.aec",  16'(o_aec), 16'd0);

    // ---------------- line wrap ----------------
    ls_pulses  = 0;
    cycle_errs = 0;
    for (int t = 52; t <= 3151; t++) begin
      tick_to(t);
      if (o_line_start === 1'b1) ls_pulses++;
      if (o_cycle !== 6'(((t - 1) / 50) % 63)) cycle_errs++;
    end
    chk("wrap.ls_pulses",  16'(ls_pulses), 16'd1);
    chk("wrap.cycle_errs", 16'(cycle_errs), 16'd0);
    chk("wrap.cycle0",     16'(o_cycle), 16'd0);
    chk("wrap.ls",         16'(o_line_start), 16'd1);
`ifdef VIC_ARB_STEAL_COUNT_EN
    chk("wrap.scnt",       o_steal_count, 16'd0);
`endif

    // ---------------- full steal: req sampled high cycles 10..20 ----------------
    line1 = 3150;
    for (int c = 9; c <= 21; c++) begin
      if (c == 10) begin
        tick_to(line1 + 500);
        i_dma_req = 1'b1;
      end
      tick_to(line1 + 50 * c + 1);
      if (c == 20) i_dma_req = 1'b0;
      exp_ba   = !(c >= 10 && c <= 20);
      exp_stol = (c >= 13 && c <= 20);
      chk($sformatf("steal.c%0d.vic.ba", c),   16'(o_ba),     16'(exp_ba));
      chk($sformatf("steal.c%0d.vic.aec", c),  16'(o_aec),    16'd0);
      chk($sformatf("steal.c%0d.vic.stol", c), 16'(o_stolen), 16'(exp_stol));
      tick_to(line1 + 50 * c + 26);
      chk($sformatf("steal.c%0d.cpu.ba", c),   16'(o_ba),     16'(exp_ba));
      chk($sformatf("steal.c%0d.cpu.aec", c),  16'(o_aec),    16'(!exp_stol));
      chk($sformatf("steal.c%0d.cpu.stol", c), 16'(o_stolen), 16'(exp_stol));
`ifdef VIC_ARB_STEAL_COUNT_EN
      if (c >= 20) chk($sformatf("steal.c%0d.scnt", c), o_steal_count, 16'd8);
`endif
    end

    // ---------------- next line start clears the count ----------------
    line2 = 6300;
    tick_to(line2 + 1);
    chk("line2.cycle", 16'(o_cycle), 16'd0);
    chk("line2.ls",    16'(o_line_start), 16'd1);
`ifdef VIC_ARB_STEAL_COUNT_EN
    chk("line2.scnt",  o_steal_count, 16'd0);
`endif

    // ---------------- aborted warning: req sampled high cycles 5..6 ----------------
    for (int c = 4; c <= 8; c++) begin
      if (c == 5) begin
        tick_to(line2 + 250);
        i_dma_req = 1'b1;
      end
      tick_to(line2 + 50 * c + 1);
      if (c == 6) i_dma_req = 1'b0;
      exp_ba = !(c == 5 || c == 6);
      chk($sformatf("abort.c%0d.ba", c),   16'(o_ba),     16'(exp_ba));
      chk($sformatf("abort.c%0d.stol", c), 16'(o_stolen), 16'd0);
      tick_to(line2 + 50 * c + 26);
      chk($sformatf("abort.c%0d.aec", c),  16'(o_aec),    16'd1);
      chk($sformatf("abort.c%0d.stol2", c),16'(o_stolen), 16'd0);
    end

    // ---------------- glitch mid CPU half of cycle 10 ----------------
    tick_to(line2 + 530);
    i_dma_req = 1'b1;
    tick_to(line2 + 540);
    chk("glitch.during.ba", 16'(o_ba), 16'd1);
    i_dma_req = 1'b0;
    tick_to(line2 + 551);
    chk("glitch.c11.ba",    16'(o_ba), 16'd1);
    chk("glitch.c11.stol",  16'(o_stolen), 16'd0);
    tick_to(line2 + 576);
    chk("glitch.c11.aec",   16'(o_aec), 16'd1);

    // ---------------- reset during STEAL (req sampled high from cycle 12) ----------------
    tick_to(line2 + 600);
    i_dma_req = 1'b1;
    tick_to(line2 + 701);
    chk("rsteal.c14.ba",   16'(o_ba), 16'd0);
    chk("rsteal.c14.stol", 16'(o_stolen), 16'd0);
    tick_to(line2 + 751);
    chk("rsteal.c15.stol", 16'(o_stolen), 16'd1);
    tick_to(line2 + 776);
    chk("rsteal.c15.aec",  16'(o_aec), 16'd0);
    chk("rsteal.c15.phi0", 16'(o_phi0), 16'd1);
    reset = 1'b1;
    #1;
    chk_reset_values("rst_async");
    i_dma_req = 1'b0;
    repeat (2) @(posedge clkSys);
    #1;
    chk_reset_values("rst_held");
    reset = 1'b0;
    now_tick = 0;
    tick_to(1);
    chk("rel.cycle", 16'(o_cycle), 16'd0);
    chk("rel.ls",    16'(o_line_start), 16'd1);
    chk("rel.ba",    16'(o_ba), 16'd1);
    chk("rel.stol",  16'(o_stolen), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
